// File: rtl/pool_pkg.sv
// Shared types for the 2x2 max-pooling front end (window buffer + pooling unit).
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional SOF resync in the window buffer is enabled by WINBUF_SOF_SYNC_EN.
package pool_pkg;

   // Default pixel width used by the pooling datapath.
   localparam int POOL_DATA_W = 16;

   // Row-parity state of the window buffer: even rows fill the line buffer,
   // odd rows pair with it to complete windows.
   typedef enum logic {
      S_EVEN = 1'b0,
      S_ODD  = 1'b1
   } win_state_t;

   // One 2x2 window; field order matches the pooling unit's input1..input4.
   typedef struct packed {
      logic [POOL_DATA_W-1:0] tl;
      logic [POOL_DATA_W-1:0] tr;
      logic [POOL_DATA_W-1:0] bl;
      logic [POOL_DATA_W-1:0] br;
   } pool_win_t;

   // Index width for a table of 'depth' entries, never less than one bit.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pool_line_ram.sv
// Simple dual-port line RAM: one synchronous write port, one combinational read port.
// Latency: write visible on the cycle after the write; read data is combinational from rd_addr.
// Backpressure: none; the owner gates wr_en.
module pool_line_ram
   import pool_pkg::*;
#(
   parameter int DATA_W = POOL_DATA_W,
   parameter int DEPTH  = 32
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [addr_w(DEPTH)-1:0] wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [addr_w(DEPTH)-1:0] rd_addr,
   output logic [DATA_W-1:0]        rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port; contents are deliberately not reset so this maps to distributed RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Asynchronous read port.
   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pool_window_buffer.sv
// Collects raster-order pixels into non-overlapping 2x2 windows for the stride-2 max-pool stage.
// Latency: a window is presented the cycle after its bottom-right pixel is accepted.
// Backpressure: in_ready = !out_valid || out_ready; nothing is accepted while a window is pending.
// Optional: WINBUF_SOF_SYNC_EN adds in_sof (frame resync) and the sticky sof_err status.
module pool_window_buffer
   import pool_pkg::*;
#(
   parameter int DATA_W = POOL_DATA_W,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
`ifdef WINBUF_SOF_SYNC_EN
   input  logic              in_sof,
   output logic              sof_err,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_tl,
   output logic [DATA_W-1:0] out_tr,
   output logic [DATA_W-1:0] out_bl,
   output logic [DATA_W-1:0] out_br,
   output logic              out_last
);

   localparam int CW = addr_w(IMG_W);
   localparam int RW = addr_w(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   // Window layout identical to pool_win_t, sized by this instance's DATA_W.
   typedef struct packed {
      logic [DATA_W-1:0] tl;
      logic [DATA_W-1:0] tr;
      logic [DATA_W-1:0] bl;
      logic [DATA_W-1:0] br;
   } win_t;

   // Geometry checks: pairing rows and columns only works for even, non-trivial sizes.
   if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_img_w
      $error("pool_window_buffer: IMG_W (%0d) must be even and >= 2", IMG_W);
   end
   if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_bad_img_h
      $error("pool_window_buffer: IMG_H (%0d) must be even and >= 2", IMG_H);
   end
   if (DATA_W < 1) begin : g_bad_data_w
      $error("pool_window_buffer: DATA_W (%0d) must be >= 1", DATA_W);
   end

   // Position / FSM state
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   win_state_t    state_q, state_d;

   // Partial-window holds: top-left comes from the line buffer on the even
   // column of an odd row, bottom-left is the odd-row even-column pixel.
   logic [DATA_W-1:0] tl_hold_q, tl_hold_d;
   logic [DATA_W-1:0] bl_q, bl_d;

   // Output window registers
   win_t win_q, win_d;
   logic out_valid_q, out_valid_d;
   logic out_last_q, out_last_d;

   // Effective position of the beat being accepted (SOF can override it).
   logic          accept;
   logic          sof_hit;
   logic [CW-1:0] pos_col;
   logic [RW-1:0] pos_row;
   win_state_t    pos_state;
   logic          last_col;
   logic          last_row;

   logic              lb_wr_en;
   logic [DATA_W-1:0] lb_rd_data;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

`ifdef WINBUF_SOF_SYNC_EN
   logic sof_err_q;

   assign sof_hit = accept && in_sof;
   assign sof_err = sof_err_q;

   // Sticky flag: a start-of-frame marker that did not land on the frame origin.
   always_ff @(posedge clk) begin
      if (reset) begin
         sof_err_q <= 1'b0;
      end else if (sof_hit && ((col_q != '0) || (row_q != '0))) begin
         sof_err_q <= 1'b1;
      end
   end
`else
   assign sof_hit = 1'b0;
`endif

   // A resync beat is processed as pixel (0,0) of an even row; stale holds are
   // simply never read again because the odd-row path rewrites them first.
   always_comb begin
      pos_col   = col_q;
      pos_row   = row_q;
      pos_state = state_q;
      if (sof_hit) begin
         pos_col   = '0;
         pos_row   = '0;
         pos_state = S_EVEN;
      end
   end

   assign last_col = (pos_col == COL_LAST);
   assign last_row = (pos_row == ROW_LAST);
   assign lb_wr_en = accept && (pos_state == S_EVEN);

   pool_line_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W)
   ) u_line_ram (
      .clk     (clk),
      .wr_en   (lb_wr_en),
      .wr_addr (pos_col),
      .wr_data (in_data),
      .rd_addr (pos_col),
      .rd_data (lb_rd_data)
   );

   // Next-state: position counters, row-parity FSM, partial holds and output window.
   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      state_d     = state_q;
      tl_hold_d   = tl_hold_q;
      bl_d        = bl_q;
      win_d       = win_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;

      // Downstream took the window; a completing beat below may reload it.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      if (accept) begin
         if (last_col) begin
            col_d   = '0;
            row_d   = last_row ? '0 : (pos_row + RW'(1));
            state_d = (pos_state == S_EVEN) ? S_ODD : S_EVEN;
         end else begin
            col_d   = pos_col + CW'(1);
            row_d   = pos_row;
            state_d = pos_state;
         end

         if (pos_state == S_ODD) begin
            if (!pos_col[0]) begin
               bl_d      = in_data;
               tl_hold_d = lb_rd_data;
            end else begin
               win_d.tl    = tl_hold_q;
               win_d.tr    = lb_rd_data;
               win_d.bl    = bl_q;
               win_d.br    = in_data;
               out_valid_d = 1'b1;
               out_last_d  = last_row && last_col;
            end
         end
      end
   end

   // State registers with synchronous reset; the line buffer is left unreset.
   always_ff @(posedge clk) begin
      if (reset) begin
         col_q       <= '0;
         row_q       <= '0;
         state_q     <= S_EVEN;
         tl_hold_q   <= '0;
         bl_q        <= '0;
         win_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         state_q     <= state_d;
         tl_hold_q   <= tl_hold_d;
         bl_q        <= bl_d;
         win_q       <= win_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_tl    = win_q.tl;
   assign out_tr    = win_q.tr;
   assign out_bl    = win_q.bl;
   assign out_br    = win_q.br;

endmodule

// File: tb/tb_pool_window_buffer.sv
// Directed bench for pool_window_buffer at IMG_W=4, IMG_H=4, pixel value = raster index.
// Latency: windows are checked one cycle after the completing pixel is accepted.
// Backpressure: stalls the output side and checks in_ready and window hold.
module tb_pool_window_buffer;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_tl, out_tr, out_bl, out_br;
   logic          out_last;
`ifdef WINBUF_SOF_SYNC_EN
   logic          in_sof = 1'b0;
   logic          sof_err;
`endif

   int checks = 0;
   int passes = 0;

   pool_window_buffer #(
      .DATA_W (DW),
      .IMG_W  (4),
      .IMG_H  (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef WINBUF_SOF_SYNC_EN
      .in_sof    (in_sof),
      .sof_err   (sof_err),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_tl    (out_tl),
      .out_tr    (out_tr),
      .out_bl    (out_bl),
      .out_br    (out_br),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, observed running, required done");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Present one pixel and hold it until accepted (bounded).
   task automatic send(input logic [DW-1:0] d);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = d;
      #0;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      chk($sformatf("accept_px%0d", d), {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic chk_win(input string tag, input int tl, input int tr, input int bl,
                          input int br, input logic last);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_tl"}, {16'd0, out_tl}, tl);
      chk({tag, "_tr"}, {16'd0, out_tr}, tr);
      chk({tag, "_bl"}, {16'd0, out_bl}, bl);
      chk({tag, "_br"}, {16'd0, out_br}, br);
      chk({tag, "_last"}, {31'd0, out_last}, {31'd0, last});
   endtask

   // Stream one 4x4 frame of base+0..base+15 with out_ready held high.
   task automatic stream_frame(input string tag, input int base);
      for (int n = 0; n < 16; n++) begin
         send(DW'(base + n));
         case (n)
            5:  chk_win($sformatf("%s_w0", tag), base + 0, base + 1, base + 4, base + 5, 1'b0);
            7:  chk_win($sformatf("%s_w1", tag), base + 2, base + 3, base + 6, base + 7, 1'b0);
            13: chk_win($sformatf("%s_w2", tag), base + 8, base + 9, base + 12, base + 13, 1'b0);
            15: chk_win($sformatf("%s_w3", tag), base + 10, base + 11, base + 14, base + 15, 1'b1);
            default: chk($sformatf("%s_novalid_px%0d", tag, n), {31'd0, out_valid}, 32'd0);
         endcase
      end
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_out_tl", {16'd0, out_tl}, 32'd0);
      chk("rst_out_br", {16'd0, out_br}, 32'd0);

      // Continuous stream, then a second frame back-to-back
      stream_frame("f0", 0);
      stream_frame("f1", 100);
      tick();
      chk("idle_valid_clear", {31'd0, out_valid}, 32'd0);

      // Output stall on the first window
      do_reset();
      for (int n = 0; n < 6; n++) send(DW'(n));
      chk_win("stall_w0", 0, 1, 4, 5, 1'b0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'd6;
      #1;
      chk("stall_in_ready0", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_win($sformatf("stall_hold%0d", i), 0, 1, 4, 5, 1'b0);
         chk($sformatf("stall_in_ready_c%0d", i), {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("stall_release_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("stall_px6_drained", {31'd0, out_valid}, 32'd0);
      send(16'd7);
      chk_win("stall_w1", 2, 3, 6, 7, 1'b0);
      for (int n = 8; n < 14; n++) send(DW'(n));
      chk_win("stall_w2", 8, 9, 12, 13, 1'b0);
      send(16'd14);
      send(16'd15);
      chk_win("stall_w3", 10, 11, 14, 15, 1'b1);

      // Mid-frame reset after pixel 9
      do_reset();
      for (int n = 0; n < 10; n++) send(DW'(n));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_out_tl", {16'd0, out_tl}, 32'd0);
      chk("midrst_out_bl", {16'd0, out_bl}, 32'd0);
      stream_frame("mr", 0);

`ifdef WINBUF_SOF_SYNC_EN
      // Resync on pixel 6 position: 200 becomes the new (0,0)
      do_reset();
      for (int n = 0; n < 6; n++) send(DW'(n));
      in_sof = 1'b1;
      send(16'd200);
      in_sof = 1'b0;
      chk("sof_err_set", {31'd0, sof_err}, 32'd1);
      chk("sof_pending_drained", {31'd0, out_valid}, 32'd0);
      for (int n = 201; n < 205; n++) send(DW'(n));
      send(16'd205);
      chk_win("sof_w0", 200, 201, 204, 205, 1'b0);
      chk("sof_err_sticky", {31'd0, sof_err}, 32'd1);
      do_reset();
      chk("sof_err_cleared", {31'd0, sof_err}, 32'd0);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
